// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type, default width and counter sizing for seq_divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    localparam int DIV_W_DEFAULT = 32;

    // Bits needed to hold the iteration index WIDTH-1 down to 0.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division iteration: shift, trial subtract, restore or keep
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // rem < dvsr always holds, so the true difference fits in WIDTH+1 signed bits.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider with start/busy/done handshake
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   z
);

    localparam int CW = cnt_w(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sgn;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] bmag;
    logic             q_neg;
    logic             r_neg;
    logic [CW-1:0]    count;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;

    always_comb begin
        a_neg   = sgn & a_reg[WIDTH-1];
        b_neg   = sgn & b_reg[WIDTH-1];
        a_mag   = a_neg ? -a_reg : a_reg;
        b_mag   = b_neg ? -b_reg : b_reg;
        rem_fix = r_neg ? -rem : rem;
        quo_fix = q_neg ? -quo : quo;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvsr     (bmag),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sgn         <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            bmag        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            z           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg       <= dividend;
                        b_reg       <= divisor;
                        sgn         <= is_signed;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= PREP;
                    end
                end
                PREP: begin
                    if (b_reg == '0) begin
                        z           <= {a_reg, {WIDTH{1'b1}}};
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        rem   <= '0;
                        quo   <= a_mag;
                        bmag  <= b_mag;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        count <= CW'(WIDTH - 1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // MIN / -1 falls out naturally: the magnitude quotient negates back to MIN.
                    z     <= {rem_fix, quo_fix};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
